aud_i2s_recorder: RTL and testbench
===================================

// Module: aud_i2s_recorder
// PURPOSE
//  Upstream capture stage of the record path. Deserialises left-channel I2S samples from the
//  WM8731 ADC (AUD_ADCDAT/ADCLRCK), clocked by the audio bit clock.
//  Emits one 16-bit sample plus SRAM word address per LRC frame to the SRAM write path in Top.
//  Start/pause/stop come from the debounced key controls; stop length goes to the player.
// PARAMETERS
//  DATA_W    16         sample width, MSB first on the serial line
//  ADDR_W    20         SRAM word-address width
//  MAX_ADDR  2**ADDR_W-1  last writable word address; recording auto-stops after it
// PORTS
//  i_clk        in   1       audio bit clock (AUD_BCLK); all logic on posedge
//  i_rst        in   1       synchronous reset, active-high
//  i_lrc        in   1       AUD_ADCLRCK; low = left channel
//  i_data       in   1       AUD_ADCDAT serial bit
//  i_start      in   1       1-cycle pulse: start new recording / resume from pause
//  i_pause      in   1       1-cycle pulse: pause recording
//  i_stop       in   1       1-cycle pulse: end recording
//  o_address    out  ADDR_W  SRAM word address of o_data
//  o_data       out  DATA_W  captured sample
//  o_valid      out  1       1-cycle write strobe; o_address/o_data valid this cycle
//  o_recording  out  1       high in WAIT_FRAME/SHIFT/STORE
//  o_full       out  1       sticky: MAX_ADDR written; cleared by next fresh i_start
//  o_last_addr  out  ADDR_W  address of last written sample (0 if none)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal address pointer, shift reg, bit counter 0; lrc_d=1.
//  lrc_d = i_lrc registered each cycle; frame start (fs) = lrc_d & ~i_lrc.
//  States: IDLE, WAIT_FRAME, SHIFT, STORE, PAUSED.
//   IDLE: i_start -> ptr=0, o_full=0, o_last_addr=0, -> WAIT_FRAME.
//   WAIT_FRAME: fs -> SHIFT, bit_cnt=0. The fs cycle is the I2S 1-bit delay slot; i_data ignored.
//   SHIFT: each cycle shreg={shreg[DATA_W-2:0],i_data}, bit_cnt++; after DATA_W-th bit -> STORE.
//    Bits sampled on the DATA_W cycles directly following the fs cycle (MSB first).
//   STORE (1 cycle): o_valid=1, o_data=shreg, o_address=ptr, o_last_addr<=ptr.
//    If ptr==MAX_ADDR: o_full<=1 -> IDLE; else ptr++ -> WAIT_FRAME.
//    Sample latency: o_valid asserts DATA_W+1 cycles after the fs cycle.
//   PAUSED: i_start -> WAIT_FRAME, ptr kept (resume appends at ptr).
//  o_data/o_address registered, hold last value when o_valid=0; o_valid is never asserted
//   outside STORE.
//  Controls (any recording state or PAUSED): priority i_stop > i_pause > i_start.
//   i_stop -> IDLE; sample in SHIFT discarded; if stop lands in STORE, that sample is still
//    written (o_valid=1) and then -> IDLE.
//   i_pause in WAIT_FRAME/SHIFT -> PAUSED, partial sample discarded; in STORE: write completes,
//    then PAUSED.
//   i_start while recording: ignored. i_pause/i_stop in IDLE: ignored.
//  fs arriving during STORE is lost; next sample is taken from the following frame (no
//   back-to-back hazard at DATA_W < frame length).
//  Right-channel half frame (i_lrc high) never captured.
//  o_full stays 1 through IDLE until a fresh i_start.
//  i_rst mid-operation: immediate return to reset values; no o_valid that cycle.
// STRUCTURE
//  aud_pkg: rec_state_e enum, DATA_W/ADDR_W defaults, I2S_DELAY_BITS=1 constant.
//  Sub-module i2s_deser: lrc edge detect, shift register, bit counter; outputs sample + done.
//  aud_i2s_recorder: FSM, address pointer, control priority, output registers.
// TESTING
//  T1 reset then i_start, 3 frames of 0xA5C3, 0x0001, 0x8000 -> o_valid x3, addr 0,1,2,
//     data exact, each 17 cycles after fs.
//  T2 i_pause at bit 7 of frame 2, i_start 5 frames later -> frame-2 data dropped, next sample
//     at addr 1, o_last_addr=1.
//  T3 i_stop+i_pause+i_start same cycle mid-SHIFT -> IDLE, no o_valid, o_recording=0.
//  T4 ADDR_W=4 -> 16 writes at addr 0..15, o_full=1, IDLE; i_start -> o_full=0, addr restarts at 0.
//  T5 i_stop in STORE cycle -> that sample written, then IDLE, o_last_addr=its addr.
//  T6 i_rst asserted mid-SHIFT -> all outputs 0 next cycle; right-channel data 0xFFFF never
//     appears on o_data.

Source files
------------

// File: rtl/aud_i2s_recorder_pkg.sv
// Shared types and constants for the I2S record path.
package aud_i2s_recorder_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 20;
  // I2S places the MSB one bit-clock after the LRC edge.
  localparam int I2S_DELAY_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_SHIFT,
    ST_STORE,
    ST_PAUSED
  } rec_state_e;

endpackage

// File: rtl/aud_i2s_recorder_if.sv
// Serial input, key controls and SRAM write side of the recorder.
interface aud_i2s_recorder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              i_lrc;
  logic              i_data;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_recording;
  logic              o_full;
  logic [ADDR_W-1:0] o_last_addr;

  modport master (
    output i_lrc, i_data, i_start, i_pause, i_stop,
    input  o_address, o_data, o_valid, o_recording, o_full, o_last_addr
  );

  modport slave (
    input  i_lrc, i_data, i_start, i_pause, i_stop,
    output o_address, o_data, o_valid, o_recording, o_full, o_last_addr
  );
endinterface

// File: rtl/aud_i2s_recorder_deser.sv
// Left-channel I2S deserialiser: LRC falling-edge detect, shift register and
// slot counter. 'sample' already includes the bit on the line this cycle so
// the parent can register the full word on the same edge that sees 'done'.
module aud_i2s_recorder_deser
  import aud_i2s_recorder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lrc,
  input  logic              sdata,
  input  logic              shift_en,
  output logic              fs,
  output logic [DATA_W-1:0] sample,
  output logic              done
);
  // bit_cnt tracks the slot position inside the left half; slot 0 is the fs cycle.
  localparam int LAST_SLOT = I2S_DELAY_BITS + DATA_W - 1;
  localparam int CNT_W     = $clog2(LAST_SLOT + 1);

  logic              lrc_d;
  logic [DATA_W-2:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  assign fs     = lrc_d & ~lrc;
  assign sample = {shreg, sdata};
  assign done   = shift_en & (bit_cnt == CNT_W'(LAST_SLOT));

  // Edge-detect history, shift register and slot counter (parked at the first data slot).
  always_ff @(posedge clk) begin
    if (rst) begin
      lrc_d   <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      lrc_d <= lrc;
      if (shift_en) begin
        shreg   <= sample[DATA_W-2:0];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= CNT_W'(I2S_DELAY_BITS);
      end
    end
  end
endmodule

// File: rtl/aud_i2s_recorder.sv
// Record-path capture stage: one left-channel sample per LRC frame is
// written to consecutive SRAM word addresses until stopped or full.
//
//  state       | meaning
//  ST_IDLE     | not recording; waits for a fresh start (resets pointer/full)
//  ST_WAIT_FRAME | armed, waiting for the LRC falling edge
//  ST_SHIFT    | collecting DATA_W bits MSB first
//  ST_STORE    | write strobe cycle; then advance pointer or flag full
//  ST_PAUSED   | halted, pointer kept; start resumes appending
module aud_i2s_recorder
  import aud_i2s_recorder_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input logic               i_clk,
  input logic               i_rst,
  aud_i2s_recorder_if.slave bus
);
  rec_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] address_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              recording_q;
  logic              full_q;

  logic              fs;
  logic              done;
  logic [DATA_W-1:0] sample;

  aud_i2s_recorder_deser #(.DATA_W(DATA_W)) u_deser (
    .clk      (i_clk),
    .rst      (i_rst),
    .lrc      (bus.i_lrc),
    .sdata    (bus.i_data),
    .shift_en (state == ST_SHIFT),
    .fs       (fs),
    .sample   (sample),
    .done     (done)
  );

  assign bus.o_address   = address_q;
  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_recording = recording_q;
  assign bus.o_full      = full_q;
  assign bus.o_last_addr = last_addr_q;

  // Recorder FSM with registered outputs; stop beats pause beats start, and
  // a full address space beats any control arriving in the store cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      address_q   <= '0;
      last_addr_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      recording_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            ptr         <= '0;
            full_q      <= 1'b0;
            last_addr_q <= '0;
            state       <= ST_WAIT_FRAME;
            recording_q <= 1'b1;
          end
        end
        ST_WAIT_FRAME: begin
          if (bus.i_stop) begin
            state       <= ST_IDLE;
            recording_q <= 1'b0;
          end else if (bus.i_pause) begin
            state       <= ST_PAUSED;
            recording_q <= 1'b0;
          end else if (fs) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.i_stop) begin
            state       <= ST_IDLE;
            recording_q <= 1'b0;
          end else if (bus.i_pause) begin
            state       <= ST_PAUSED;
            recording_q <= 1'b0;
          end else if (done) begin
            state       <= ST_STORE;
            valid_q     <= 1'b1;
            data_q      <= sample;
            address_q   <= ptr;
            last_addr_q <= ptr;
          end
        end
        ST_STORE: begin
          if (ptr == MAX_ADDR) begin
            full_q      <= 1'b1;
            state       <= ST_IDLE;
            recording_q <= 1'b0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
            if (bus.i_stop) begin
              state       <= ST_IDLE;
              recording_q <= 1'b0;
            end else if (bus.i_pause) begin
              state       <= ST_PAUSED;
              recording_q <= 1'b0;
            end else begin
              state <= ST_WAIT_FRAME;
            end
          end
        end
        ST_PAUSED: begin
          if (bus.i_stop) begin
            state <= ST_IDLE;
          end else if (bus.i_start) begin
            state       <= ST_WAIT_FRAME;
            recording_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          recording_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Bench for aud_i2s_recorder: directed frame table plus randomized frames
// against a frame-level behavioural model. Uses a 4-bit address space.
module tb_aud_i2s_recorder;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int MAXA  = 15;
  localparam int H_DIR = 20;
  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_START = 3'b001;
  localparam logic [2:0] C_PAUSE = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b100;

  typedef struct {
    logic [DW-1:0] smp;
    logic [2:0]    ctl;
    int            pos;
    int            rst_pos;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
    bit            exp_rec;
    logic [AW-1:0] exp_last;
    bit            exp_full;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  aud_i2s_recorder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  aud_i2s_recorder #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0 idle, 1 paused, 2 recording
  int m_mode, m_ptr, m_last;
  bit m_full;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.o_valid), 0);
    check({tag, "_data"},  32'(bus.o_data), 0);
    check({tag, "_addr"},  32'(bus.o_address), 0);
    check({tag, "_rec"},   32'(bus.o_recording), 0);
    check({tag, "_full"},  32'(bus.o_full), 0);
    check({tag, "_last"},  32'(bus.o_last_addr), 0);
  endtask

  // One LRC frame: h cycles left (slot 0 = delay slot, slots 1..16 = sample), h cycles right.
  task automatic run_frame(input int h, input logic [DW-1:0] smp, input logic [2:0] ctl,
                           input int pos, input int rst_pos, input bit rnd_right,
                           output int nval, output logic [AW-1:0] vaddr,
                           output logic [DW-1:0] vdata, output int vidx);
    nval = 0; vaddr = '0; vdata = '0; vidx = -1;
    for (int i = 0; i < 2 * h; i++) begin
      bus.i_lrc = (i >= h);
      if (i < h) begin
        if (i >= 1 && i <= DW) bus.i_data = smp[DW-i];
        else bus.i_data = 1'($urandom);
      end else begin
        bus.i_data = rnd_right ? 1'($urandom) : 1'b1;
      end
      bus.i_start = (i == pos) & ctl[0];
      bus.i_pause = (i == pos) & ctl[1];
      bus.i_stop  = (i == pos) & ctl[2];
      i_rst = (i == rst_pos);
      tick();
      if (bus.o_valid) begin
        nval++;
        vaddr = bus.o_address;
        vdata = bus.o_data;
        vidx  = i;
      end
      if (i == rst_pos) check_zero("rst_mid");
    end
    bus.i_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_stop  = 1'b0;
    i_rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [DW-1:0] smp, input logic [2:0] ctl, input int pos,
                              input int rst_pos, input bit wr, input int addr, input bit rec,
                              input int last, input bit full);
    vec_t v;
    v.smp = smp; v.ctl = ctl; v.pos = pos; v.rst_pos = rst_pos; v.exp_wr = wr;
    v.exp_addr = AW'(addr); v.exp_rec = rec; v.exp_last = AW'(last); v.exp_full = full;
    return v;
  endfunction

  task automatic model_ctl(input logic [2:0] k);
    if (k == C_STOP) begin
      m_mode = 0;
    end else if (k == C_PAUSE) begin
      if (m_mode == 2) m_mode = 1;
    end else if (k == C_START) begin
      if (m_mode == 0) begin
        m_mode = 2; m_ptr = 0; m_last = 0; m_full = 0;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    int nval, vidx;
    logic [AW-1:0] vaddr;
    logic [DW-1:0] vdata;

    bus.i_lrc = 1'b1; bus.i_data = 1'b0;
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
    i_rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    i_rst = 1'b0;
    tick();

    // smp, ctl, pos, rst_pos, wr, addr, rec, last, full
    tbl.push_back(mk(16'h5A5A, C_START, 22, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16'hA5C3, C_NONE, -1, -1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(16'h0001, C_NONE, -1, -1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(16'h8000, C_NONE, -1, -1, 1, 2, 1, 2, 0));
    tbl.push_back(mk(16'h1357, C_STOP, 22, -1, 1, 3, 0, 3, 0));
    tbl.push_back(mk(16'h2468, C_START, 22, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16'h1111, C_NONE, -1, -1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(16'h2222, C_PAUSE, 8, -1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(16'h3333, C_NONE, -1, -1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h4444, C_START, 22, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16'h5555, C_NONE, -1, -1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(16'h6666, C_STOP | C_PAUSE | C_START, 8, -1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(16'h7777, C_START, 22, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16'hBEEF, C_NONE, -1, -1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(16'hCAFE, C_STOP, 17, -1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(16'h0000, C_START, 22, -1, 0, 0, 1, 0, 0));
    for (int k = 0; k <= MAXA; k++)
      tbl.push_back(mk(16'(16'hC000 + k * 257), C_NONE, -1, -1, 1, k, k != MAXA, k, k == MAXA));
    tbl.push_back(mk(16'h9999, C_START, 22, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16'h0ABC, C_NONE, -1, -1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(16'hF00F, C_NONE, -1, 8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h1234, C_START, 22, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(16'h0FF0, C_NONE, -1, -1, 1, 0, 1, 0, 0));

    foreach (tbl[r]) begin
      run_frame(H_DIR, tbl[r].smp, tbl[r].ctl, tbl[r].pos, tbl[r].rst_pos, 1'b0,
                nval, vaddr, vdata, vidx);
      check($sformatf("row%0d_nvalid", r), nval, 32'(tbl[r].exp_wr));
      if (tbl[r].exp_wr) begin
        check($sformatf("row%0d_addr", r), 32'(vaddr), 32'(tbl[r].exp_addr));
        check($sformatf("row%0d_data", r), 32'(vdata), 32'(tbl[r].smp));
        check($sformatf("row%0d_latency", r), vidx, DW);
      end
      check($sformatf("row%0d_rec", r), 32'(bus.o_recording), 32'(tbl[r].exp_rec));
      check($sformatf("row%0d_last", r), 32'(bus.o_last_addr), 32'(tbl[r].exp_last));
      check($sformatf("row%0d_full", r), 32'(bus.o_full), 32'(tbl[r].exp_full));
    end

    // Randomized frames against the frame-level model.
    bus.i_lrc = 1'b1;
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    tick();
    m_mode = 0; m_ptr = 0; m_last = 0; m_full = 0;
    for (int f = 0; f < 150; f++) begin
      int h, pos, sel, e_addr;
      bit cap, handled;
      logic [2:0] ctl;
      logic [DW-1:0] smp;
      h = $urandom_range(24, 18);
      smp = 16'($urandom);
      ctl = C_NONE;
      pos = -1;
      if ($urandom_range(99, 0) < 35) begin
        sel = $urandom_range(3, 0);
        ctl = (sel < 2) ? C_START : (sel == 2) ? C_PAUSE : C_STOP;
        pos = $urandom_range(2 * h - 1, 0);
      end
      cap = (m_mode == 2);
      if (cap && m_ptr == MAXA && pos == 17) pos = 18;
      handled = 0;
      e_addr = 0;
      if (cap && ctl != C_NONE && pos <= 17) begin
        if (ctl == C_START) handled = 1;
        else if (pos <= DW) begin
          cap = 0;
          model_ctl(ctl);
          handled = 1;
        end
      end
      if (cap) begin
        e_addr = m_ptr;
        m_last = m_ptr;
        if (m_ptr == MAXA) begin
          m_full = 1;
          m_mode = 0;
        end else begin
          m_ptr++;
        end
      end
      if (ctl != C_NONE && !handled) model_ctl(ctl);

      run_frame(h, smp, ctl, pos, -1, 1'b1, nval, vaddr, vdata, vidx);
      check($sformatf("rnd%0d_nvalid", f), nval, 32'(cap));
      if (cap) begin
        check($sformatf("rnd%0d_addr", f), 32'(vaddr), e_addr);
        check($sformatf("rnd%0d_data", f), 32'(vdata), 32'(smp));
        check($sformatf("rnd%0d_latency", f), vidx, DW);
      end
      check($sformatf("rnd%0d_rec", f), 32'(bus.o_recording), 32'(m_mode == 2));
      check($sformatf("rnd%0d_last", f), 32'(bus.o_last_addr), m_last);
      check($sformatf("rnd%0d_full", f), 32'(bus.o_full), 32'(m_full));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
